// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: RGB -> luma, two line buffers, 3x3 window,
// |Gx|+|Gy| magnitude with a per-frame threshold, five-stage fixed-latency pipeline.
module sobel_edge_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  VGA_VS,
    input  logic                  pix_valid,
    input  logic [PIX_BITS-1:0]   VGA_R,
    input  logic [PIX_BITS-1:0]   VGA_G,
    input  logic [PIX_BITS-1:0]   VGA_B,
    input  logic [PIX_BITS+2:0]   threshold,
    output logic                  out_valid,
    output logic [PIX_BITS+2:0]   edge_mag,
    output logic                  edge_detected,
    output logic [9:0]            out_x,
    output logic [9:0]            out_y,
    output logic                  frame_overflow
);

    localparam int GW = PIX_BITS + 3;
    localparam int XW = $clog2(IMG_WIDTH);

    logic [PIX_BITS+1:0] luma_sum_s;
    logic [PIX_BITS-1:0] luma_s;
    logic                accept_s;
    logic                win_done_s;
    logic [XW-1:0]       xa_s;
    logic [GW-1:0]       gx_pos_s, gx_neg_s, gy_pos_s, gy_neg_s;

    logic [9:0]          xi_r, yi_r;
    logic                synced_r, full_r;
    logic [GW-1:0]       thr_r;

    logic [PIX_BITS-1:0] lb0_r [IMG_WIDTH];
    logic [PIX_BITS-1:0] lb1_r [IMG_WIDTH];
    logic [PIX_BITS-1:0] win_r [3][3];

    logic                v1_r, v2_r, v3_r, v4_r;
    logic                b1_r, b2_r, b3_r, b4_r;
    logic [9:0]          cx1_r, cx2_r, cx3_r, cx4_r;
    logic [9:0]          cy1_r, cy2_r, cy3_r, cy4_r;
    logic signed [GW-1:0] gx2_r, gy2_r;
    logic [GW-1:0]       ax3_r, ay3_r, mag4_r;

    // Luma, acceptance qualifier and column taps of the current window.
    always_comb begin
        luma_sum_s = (PIX_BITS+2)'(VGA_R) + ((PIX_BITS+2)'(VGA_G) << 1) + (PIX_BITS+2)'(VGA_B);
        luma_s     = PIX_BITS'(luma_sum_s >> 2);
        accept_s   = pix_valid & VGA_VS & synced_r & ~full_r;
        win_done_s = (xi_r != 10'd0) && (yi_r != 10'd0);
        xa_s       = XW'(xi_r);
        gx_pos_s   = GW'(win_r[0][2]) + (GW'(win_r[1][2]) << 1) + GW'(win_r[2][2]);
        gx_neg_s   = GW'(win_r[0][0]) + (GW'(win_r[1][0]) << 1) + GW'(win_r[2][0]);
        gy_pos_s   = GW'(win_r[2][0]) + (GW'(win_r[2][1]) << 1) + GW'(win_r[2][2]);
        gy_neg_s   = GW'(win_r[0][0]) + (GW'(win_r[0][1]) << 1) + GW'(win_r[0][2]);
    end

    // Line buffers and window shift; contents are don't-care after reset since
    // border centres are forced to zero downstream.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb0_r[xa_s] <= lb1_r[xa_s];
            lb1_r[xa_s] <= luma_s;
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[0][2] <= lb0_r[xa_s];
            win_r[1][2] <= lb1_r[xa_s];
            win_r[2][2] <= luma_s;
        end
    end

    // Counters, frame control and the gradient pipeline.
    always_ff @(posedge clk) begin
        if (!reset) begin
            xi_r <= 10'd0;  yi_r <= 10'd0;
            synced_r <= 1'b0;  full_r <= 1'b0;  thr_r <= {GW{1'b0}};
            v1_r <= 1'b0;  v2_r <= 1'b0;  v3_r <= 1'b0;  v4_r <= 1'b0;
            out_valid <= 1'b0;  edge_mag <= {GW{1'b0}};  edge_detected <= 1'b0;
            out_x <= 10'd0;  out_y <= 10'd0;  frame_overflow <= 1'b0;
        end else if (!VGA_VS) begin
            xi_r <= 10'd0;  yi_r <= 10'd0;
            synced_r <= 1'b1;  full_r <= 1'b0;  thr_r <= threshold;
            v1_r <= 1'b0;  v2_r <= 1'b0;  v3_r <= 1'b0;  v4_r <= 1'b0;
            out_valid <= 1'b0;  frame_overflow <= 1'b0;
        end else begin
            if (accept_s) begin
                if (xi_r == 10'(IMG_WIDTH - 1)) begin
                    xi_r <= 10'd0;
                    if (yi_r == 10'(IMG_HEIGHT - 1)) begin
                        yi_r   <= 10'd0;
                        full_r <= 1'b1;
                    end else begin
                        yi_r <= yi_r + 10'd1;
                    end
                end else begin
                    xi_r <= xi_r + 10'd1;
                end
            end else if (pix_valid && synced_r && full_r) begin
                frame_overflow <= 1'b1;
            end

            // Stage 1: window complete; centre sits one column and one row back.
            v1_r  <= accept_s & win_done_s;
            cx1_r <= xi_r - 10'd1;
            cy1_r <= yi_r - 10'd1;
            b1_r  <= (xi_r == 10'd1) || (yi_r == 10'd1);

            v2_r <= v1_r;  cx2_r <= cx1_r;  cy2_r <= cy1_r;  b2_r <= b1_r;
            gx2_r <= gx_pos_s - gx_neg_s;
            gy2_r <= gy_pos_s - gy_neg_s;

            v3_r <= v2_r;  cx3_r <= cx2_r;  cy3_r <= cy2_r;  b3_r <= b2_r;
            ax3_r <= gx2_r[GW-1] ? -gx2_r : gx2_r;
            ay3_r <= gy2_r[GW-1] ? -gy2_r : gy2_r;

            v4_r <= v3_r;  cx4_r <= cx3_r;  cy4_r <= cy3_r;  b4_r <= b3_r;
            mag4_r <= b3_r ? {GW{1'b0}} : ax3_r + ay3_r;

            out_valid <= v4_r;
            if (v4_r) begin
                edge_mag      <= mag4_r;
                edge_detected <= ~b4_r & (mag4_r >= thr_r);
                out_x         <= cx4_r;
                out_y         <= cy4_r;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Self-checking bench for sobel_edge_stream on an 8x6 frame against a frame-array reference model.
module tb_sobel_edge_stream;

    localparam int W = 8;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        reset, vs, pv;
    logic [7:0]  r_in, g_in, b_in;
    logic [10:0] thr_in;
    logic        out_valid, edge_detected, frame_overflow;
    logic [10:0] edge_mag;
    logic [9:0]  out_x, out_y;

    sobel_edge_stream #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_BITS(8)) dut (
        .clk(clk), .reset(reset), .VGA_VS(vs), .pix_valid(pv),
        .VGA_R(r_in), .VGA_G(g_in), .VGA_B(b_in), .threshold(thr_in),
        .out_valid(out_valid), .edge_mag(edge_mag), .edge_detected(edge_detected),
        .out_x(out_x), .out_y(out_y), .frame_overflow(frame_overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int x; int y; int mag; int det; } res_t;
    res_t q[$];
    int img[H][W];
    int n_checks = 0, n_fails = 0, cyc = 0;
    int m_xi, m_yi, m_thr;
    bit m_sync, m_full;
    int e_valid, e_mag, e_det, e_x, e_y, e_ovf;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int px(input int cx, input int cy, input int r, input int c);
        return img[cy - 1 + r][cx - 1 + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Reference behaviour for one clock edge using the inputs presented to it.
    task automatic model_edge();
        res_t res;
        int gx, gy, cx, cy;
        if (!reset) begin
            m_xi = 0; m_yi = 0; m_thr = 0; m_sync = 0; m_full = 0;
            e_valid = 0; e_mag = 0; e_det = 0; e_x = 0; e_y = 0; e_ovf = 0;
            q.delete();
        end else if (!vs) begin
            m_xi = 0; m_yi = 0; m_full = 0; m_sync = 1; m_thr = int'(thr_in);
            e_valid = 0; e_ovf = 0;
            q.delete();
        end else begin
            e_valid = 0;
            if (q.size() > 0 && q[0].due == cyc) begin
                res = q.pop_front();
                e_valid = 1; e_x = res.x; e_y = res.y; e_mag = res.mag; e_det = res.det;
            end
            if (pv && m_sync) begin
                if (m_full) begin
                    e_ovf = 1;
                end else begin
                    img[m_yi][m_xi] = (int'(r_in) + 2 * int'(g_in) + int'(b_in)) / 4;
                    if (m_xi >= 1 && m_yi >= 1) begin
                        cx = m_xi - 1; cy = m_yi - 1;
                        res.due = cyc + 4; res.x = cx; res.y = cy;
                        if (cx == 0 || cy == 0) begin
                            res.mag = 0; res.det = 0;
                        end else begin
                            gx = px(cx,cy,0,2) + 2*px(cx,cy,1,2) + px(cx,cy,2,2)
                               - px(cx,cy,0,0) - 2*px(cx,cy,1,0) - px(cx,cy,2,0);
                            gy = px(cx,cy,2,0) + 2*px(cx,cy,2,1) + px(cx,cy,2,2)
                               - px(cx,cy,0,0) - 2*px(cx,cy,0,1) - px(cx,cy,0,2);
                            res.mag = iabs(gx) + iabs(gy);
                            res.det = (res.mag >= m_thr) ? 1 : 0;
                        end
                        q.push_back(res);
                    end
                    m_xi++;
                    if (m_xi == W) begin
                        m_xi = 0; m_yi++;
                        if (m_yi == H) begin m_yi = 0; m_full = 1; end
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        chk("out_valid", int'(out_valid), e_valid);
        chk("frame_overflow", int'(frame_overflow), e_ovf);
        chk("edge_mag", int'(edge_mag), e_mag);
        chk("edge_detected", int'(edge_detected), e_det);
        chk("out_x", int'(out_x), e_x);
        chk("out_y", int'(out_y), e_y);
    endtask

    task automatic vs_pulse(input int thr, input bit with_pix);
        vs = 1'b0; pv = with_pix; thr_in = 11'(thr);
        step(); step();
        vs = 1'b1; pv = 1'b0;
    endtask

    task automatic idle(input int n);
        pv = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // pattern 0: flat grey 100; 1: dark left half / bright right half; 2: random RGB
    task automatic send_pixels(input int pattern, input int npix, input int fixed_gap,
                               input int rand_gap, input int thr_mid);
        int gap, v;
        for (int p = 0; p < npix; p++) begin
            gap = fixed_gap + ((rand_gap > 0) ? int'($urandom_range(rand_gap, 0)) : 0);
            if (p > 0) idle(gap);
            if (p == npix / 2) thr_in = 11'(thr_mid);
            pv = 1'b1;
            case (pattern)
                0: begin r_in = 8'd100; g_in = 8'd100; b_in = 8'd100; end
                1: begin
                    v = ((p % W) < 4) ? 0 : 255;
                    r_in = 8'(v); g_in = 8'(v); b_in = 8'(v);
                end
                default: begin
                    r_in = 8'($urandom); g_in = 8'($urandom); b_in = 8'($urandom);
                end
            endcase
            step();
        end
        pv = 1'b0;
    endtask

    initial begin
        reset = 1'b0; vs = 1'b1; pv = 1'b0;
        r_in = 8'd0; g_in = 8'd0; b_in = 8'd0; thr_in = 11'd0;
        step(); step();
        reset = 1'b1;

        send_pixels(0, 5, 0, 0, 0);
        idle(6);

        vs_pulse(500, 1'b0);
        send_pixels(0, 48, 0, 0, 500);
        idle(6);

        vs_pulse(500, 1'b0);
        send_pixels(1, 48, 0, 0, 2000);
        idle(6);
        vs_pulse(2000, 1'b0);
        send_pixels(1, 48, 0, 0, 2000);
        idle(6);

        vs_pulse(100, 1'b0);
        send_pixels(2, 48, 3, 0, 100);
        idle(6);

        vs_pulse(300, 1'b0);
        send_pixels(2, 50, 0, 0, 300);
        idle(6);
        vs_pulse(300, 1'b0);
        idle(3);

        for (int f = 0; f < 3; f++) begin
            vs_pulse(int'($urandom_range(1200, 0)), 1'b0);
            send_pixels(2, 48, 0, 2, int'($urandom_range(1200, 0)));
            idle(6);
        end

        vs_pulse(400, 1'b0);
        send_pixels(2, 20, 0, 0, 400);
        vs_pulse(400, 1'b1);
        send_pixels(2, 48, 0, 1, 400);
        idle(6);

        vs_pulse(400, 1'b0);
        send_pixels(2, 20, 0, 0, 400);
        reset = 1'b0; pv = 1'b1;
        step();
        reset = 1'b1;
        send_pixels(2, 10, 0, 0, 400);
        idle(6);
        vs_pulse(400, 1'b0);
        send_pixels(2, 48, 0, 2, 400);
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
Parametrised streaming Sobel edge detector: the next generation of the VGA-fed 3x3 gradient pipeline. Accepts one RGB pixel per qualified clock, converts it to luma, and keeps two internal line buffers of depth IMG_WIDTH. Builds a 3x3 window and emits, per window centre, the gradient magnitude |Gx|+|Gy| plus a thresholded edge bit, with pixel coordinates. Sits between the VGA/video input and downstream feature logic (Harris response, overlay).

Parameters:
IMG_WIDTH, 640, pixels per line; line buffer depth; x counter wrap point.
IMG_HEIGHT, 480, lines per frame; y counter limit.
PIX_BITS, 8, width of each colour channel and of luma.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low reset.
VGA_VS  in  1  active-low vertical sync; low = frame boundary.
pix_valid  in  1  qualifies VGA_R/G/B this cycle.
VGA_R  in  PIX_BITS  red.
VGA_G  in  PIX_BITS  green.
VGA_B  in  PIX_BITS  blue.
threshold  in  PIX_BITS+3  edge threshold; sampled only while VGA_VS low.
out_valid  out  1  result strobe.
edge_mag  out  PIX_BITS+3  |Gx|+|Gy| of window centre.
edge_detected  out  1  edge_mag >= latched threshold.
out_x  out  10  centre column.
out_y  out  10  centre row.
frame_overflow  out  1  sticky: pixels received beyond IMG_WIDTH*IMG_HEIGHT.

Behaviour:
- Reset (reset==0 at clk edge): out_valid, edge_mag, edge_detected, out_x, out_y and frame_overflow = 0. Pixel counters = 0, latched threshold = 0, all pipeline valid bits cleared. Line buffer contents are don't-care.
- Luma = (R + 2G + B) >> 2, computed at PIX_BITS+2 bits, truncated to PIX_BITS.
- Accepted pixel: pix_valid==1, VGA_VS==1, and frame not yet full. Only accepted pixels write the line buffers, shift the window and advance counters.
- Counters (xi, yi): xi increments per accepted pixel and wraps IMG_WIDTH-1 -> 0 with yi+1. After (IMG_WIDTH-1, IMG_HEIGHT-1) the frame is full.
- Once full, further pix_valid pixels are dropped and frame_overflow is set.
- VGA_VS low:
  - xi = yi = 0.
  - frame_overflow cleared.
  - threshold latched.
  - In-flight pipeline valid bits flushed; no out_valid while VGA_VS low.
  - VGA_VS low takes precedence over a simultaneous pix_valid.
- Window: an accepted pixel at (xi, yi) with xi>=1 and yi>=1 completes the window for centre (cx, cy) = (xi-1, yi-1). Pixels with xi==0 or yi==0 produce no result.
- Results per frame = (IMG_WIDTH-1)*(IMG_HEIGHT-1). Column IMG_WIDTH-1 and row IMG_HEIGHT-1 are never emitted.
- Border: if cx==0 or cy==0, edge_mag = 0 and edge_detected = 0. Stale line-buffer or wrapped window data must never leak into these outputs.
- Gradients on window w[r][c], r,c in 0..2, row 0 oldest:
  - Gx = (w02 + 2w12 + w22) - (w00 + 2w10 + w20).
  - Gy = (w20 + 2w21 + w22) - (w00 + 2w01 + w02).
  - Signed, PIX_BITS+3 bits.
  - Magnitude = |Gx| + |Gy|, maximum 8*(2^PIX_BITS - 1), which fits PIX_BITS+3 unsigned. No saturation is needed.
- Latency: the pipeline is fixed and non-stallable, with no backpressure. If the completing pixel is sampled at edge t, out_valid is high for exactly the cycle following edge t+4, with the matching out_x/out_y/edge_mag.
- Back-to-back accepted pixels give back-to-back out_valid. Gaps in pix_valid propagate as equal gaps.
- Outputs hold their last value when out_valid==0.
- Reset mid-frame: takes effect at the next edge and discards everything in flight. Processing resumes only after the next VGA_VS low.
- Threshold changes while VGA_VS high are ignored until the next frame boundary.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=6; VS pulse, then 48 pixels with R=G=B=100 -> 35 out_valid strobes, all edge_mag=0, edge_detected=0, coordinates raster from (0,0) to (6,4).
- Same size, threshold=500; luma 0 for columns 0-3 and 255 for columns 4-7 -> cx=3 and cx=4 with cy>=1 give edge_mag=1020, edge_detected=1. All other centres give 0, including cx=0 or cy=0.
- Single pixel completing window (1,1) sampled at edge t -> out_valid asserted only after edge t+4, out_x=0, out_y=0; pix_valid gaps of 3 cycles reproduce 3-cycle out_valid gaps.
- Send 50 pixels into an 8x6 frame -> last 2 dropped, frame_overflow=1, exactly 35 results; next VS low clears frame_overflow.
- Change threshold from 500 to 2000 mid-frame on the step image -> edge_detected stays 1 at 1020 for the rest of the frame; after the next VS it becomes 0.
- Assert reset low mid-frame for 1 cycle -> all outputs 0 next cycle. No out_valid until a new VS low followed by 9+ pixels forming the first complete window.
